codec_burst_scheduler: RTL and testbench

- Sequences the shared CODEC between two bursting clients: an encode client (16-bit words in, 4-bit codes out) and a decode client (codes in, words out).
- Arbitrates whole bursts round-robin and drives the CODEC mode pin and the CODEC clear.
- Drives the tri-state bus enables, including a turnaround gap on every mode change.
- Counts words in each burst and flags each CODEC output valid after a fixed latency.

---
 rtl/codec_burst_scheduler.sv | 169 ++++++++++++++++
 tb/tb_codec_burst_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/codec_burst_scheduler.sv
// codec_burst_scheduler
//   Shares one CODEC between an encode client and a decode client. Whole
//   bursts are granted round-robin. The block drives the CODEC mode pin and
//   clear, the DATA/CODE bus enables (with a turnaround gap on a mode change),
//   counts the words in each burst, and flags each CODEC output as valid LAT
//   cycles after its input word was accepted.
// Ports
//   CLK, RESET_            clock, asynchronous active-low reset
//   enc_req/enc_len        encode client request and burst length
//   enc_gnt/enc_done       encode ownership, one-cycle completion pulse
//   dec_req/dec_len        decode client request and burst length
//   dec_gnt/dec_done       decode ownership, one-cycle completion pulse
//   in_valid/in_ready      input word handshake for the granted client
//   out_valid              CODEC output valid for the granted client
//   codec_encode_n         CODEC mode, 0 = encode, 1 = decode
//   codec_rst_n            CODEC clear, active low
//   data_oe/code_oe        client drives DATA / CODE bus
//   busy                   scheduler is not idle
module codec_burst_scheduler #(
  parameter int LENW   = 16,
  parameter int SETTLE = 2,
  parameter int LAT    = 1
) (
  input  logic            CLK,
  input  logic            RESET_,
  input  logic            enc_req,
  input  logic [LENW-1:0] enc_len,
  output logic            enc_gnt,
  output logic            enc_done,
  input  logic            dec_req,
  input  logic [LENW-1:0] dec_len,
  output logic            dec_gnt,
  output logic            dec_done,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  output logic            codec_encode_n,
  output logic            codec_rst_n,
  output logic            data_oe,
  output logic            code_oe,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, SWITCH, CLEAR, STREAM, DRAIN, DONE} state_t;

  // One down-counter serves both the turnaround gap and the drain window.
  localparam int TMAX = (SETTLE > LAT) ? SETTLE : LAT;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  state_t          state;
  logic            cur_dec;   // burst in progress is a decode burst
  logic            last_dec;  // decode was served last (round-robin)
  logic [LENW-1:0] blen;
  logic [LENW-1:0] cnt;
  logic [TW-1:0]   tcnt;
  logic [LAT:1]    vld_pipe;

  logic            accept;
  logic            pick_dec;
  logic [LENW-1:0] pick_len;

  assign accept    = in_valid && in_ready;
  // On a tie the client not served last wins.
  assign pick_dec  = dec_req && (!enc_req || !last_dec);
  assign pick_len  = pick_dec ? dec_len : enc_len;
  assign out_valid = vld_pipe[LAT];

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state          <= IDLE;
      cur_dec        <= 1'b0;
      last_dec       <= 1'b1;
      blen           <= '0;
      cnt            <= '0;
      tcnt           <= '0;
      vld_pipe       <= '0;
      enc_gnt        <= 1'b0;
      dec_gnt        <= 1'b0;
      enc_done       <= 1'b0;
      dec_done       <= 1'b0;
      in_ready       <= 1'b0;
      codec_encode_n <= 1'b0;
      codec_rst_n    <= 1'b0;
      data_oe        <= 1'b0;
      code_oe        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      enc_done    <= 1'b0;
      dec_done    <= 1'b0;
      codec_rst_n <= 1'b1;
      vld_pipe[1] <= accept;
      for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

      case (state)
        IDLE: begin
          if (enc_req || dec_req) begin
            cur_dec <= pick_dec;
            blen    <= pick_len;
            cnt     <= '0;
            enc_gnt <= !pick_dec;
            dec_gnt <= pick_dec;
            busy    <= 1'b1;
            if (pick_len == '0) begin
              // Empty burst: one cycle in DRAIN so done lands one cycle after gnt.
              state <= DRAIN;
              tcnt  <= '0;
            end else if (pick_dec != codec_encode_n) begin
              codec_encode_n <= pick_dec;
              if (SETTLE == 0) begin
                state       <= CLEAR;
                codec_rst_n <= 1'b0;
              end else begin
                state <= SWITCH;
                tcnt  <= TW'(SETTLE - 1);
              end
            end else begin
              state       <= CLEAR;
              codec_rst_n <= 1'b0;
            end
          end
        end
        SWITCH: begin
          if (tcnt == '0) begin
            state       <= CLEAR;
            codec_rst_n <= 1'b0;
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        CLEAR: begin
          state    <= STREAM;
          in_ready <= 1'b1;
          data_oe  <= !cur_dec;
          code_oe  <= cur_dec;
        end
        STREAM: begin
          if (accept) begin
            cnt <= cnt + LENW'(1);
            if (cnt + LENW'(1) == blen) begin
              in_ready <= 1'b0;
              data_oe  <= 1'b0;
              code_oe  <= 1'b0;
              state    <= DRAIN;
              tcnt     <= TW'(LAT - 1);
            end
          end
        end
        DRAIN: begin
          if (tcnt == '0) begin
            state    <= DONE;
            enc_done <= !cur_dec;
            dec_done <= cur_dec;
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          enc_gnt  <= 1'b0;
          dec_gnt  <= 1'b0;
          busy     <= 1'b0;
          last_dec <= cur_dec;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_burst_scheduler.sv
// Self-checking bench for codec_burst_scheduler. Each burst's expected
// waveform is laid out as a timeline (grant window, switch gap, clear cycle,
// stream window, output pulses, done cycle) and compared cycle by cycle.
module tb_codec_burst_scheduler;
  localparam int LENW   = 16;
  localparam int SETTLE = 2;
  localparam int LAT    = 1;

  logic            CLK, RESET_;
  logic            enc_req, dec_req, in_valid;
  logic [LENW-1:0] enc_len, dec_len;
  logic            enc_gnt, enc_done, dec_gnt, dec_done, in_ready, out_valid;
  logic            codec_encode_n, codec_rst_n, data_oe, code_oe, busy;

  codec_burst_scheduler #(.LENW(LENW), .SETTLE(SETTLE), .LAT(LAT)) dut (
    .CLK(CLK), .RESET_(RESET_),
    .enc_req(enc_req), .enc_len(enc_len), .enc_gnt(enc_gnt), .enc_done(enc_done),
    .dec_req(dec_req), .dec_len(dec_len), .dec_gnt(dec_gnt), .dec_done(dec_done),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .codec_encode_n(codec_encode_n), .codec_rst_n(codec_rst_n),
    .data_oe(data_oe), .code_oe(code_oe), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: current CODEC mode and who was served last.
  bit mode_dec = 1'b0;
  bit last_dec = 1'b1;
  bit pat[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {enc_gnt, enc_done, dec_gnt, dec_done, in_ready, out_valid,
            codec_encode_n, codec_rst_n, data_oe, code_oe, busy};
  endfunction

  // Idle cycles: no requests, only mode pin and deasserted clear expected.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      enc_req = 0; dec_req = 0; in_valid = 1'($urandom);
      @(negedge CLK);
      chk("idle", 32'(outs()), 32'({6'b0, mode_dec, 1'b1, 3'b0}));
      @(posedge CLK); #1;
    end
  endtask

  // Starts in an IDLE cycle (just after a rising edge), ends in the IDLE
  // cycle following the burst's done.
  task automatic run_burst(input bit er, input bit dr, input int el, input int dl,
                           input int dens, input string tag);
    bit wd, chg;
    int sw, ts, tl, tdone, n, c, pulses;
    int len;
    bit iv[0:1023];
    bit ov[0:1023];
    bit gn, str, md;
    logic [10:0] exp;
    wd  = (er && dr) ? !last_dec : dr;
    len = wd ? dl : el;
    chg = (len != 0) && (wd != mode_dec);
    sw  = chg ? SETTLE : 0;
    ts  = 2 + sw;
    tl  = 0;
    for (int i = 0; i < 1024; i++) begin
      iv[i] = ($urandom_range(0, 99) < dens);
      ov[i] = 1'b0;
    end
    if (len == 0) tdone = 2;
    else begin
      n = 0; c = ts;
      while (n < len) begin
        if (pat.size() > 0) iv[c] = pat.pop_front();
        else if (c > ts + 400) iv[c] = 1'b1;
        if (iv[c]) begin n++; ov[c + LAT] = 1'b1; tl = c; end
        c++;
      end
      tdone = tl + LAT + 1;
    end
    pulses = 0;
    for (int cy = 0; cy <= tdone; cy++) begin
      if (cy == 0) begin
        enc_req = er; dec_req = dr;
        enc_len = LENW'(el); dec_len = LENW'(dl);
      end else begin
        enc_req = 0; dec_req = 0;
        enc_len = LENW'($urandom); dec_len = LENW'($urandom);
      end
      in_valid = iv[cy];
      @(negedge CLK);
      gn  = (cy >= 1);
      str = (len != 0) && (cy >= ts) && (cy <= tl);
      md  = (chg && cy >= 1) ? wd : mode_dec;
      exp = {gn && !wd, cy == tdone && !wd, gn && wd, cy == tdone && wd, str, ov[cy],
             md, !(len != 0 && cy == 1 + sw), str && !wd, str && wd, gn};
      chk($sformatf("%s c%0d", tag, cy), 32'(outs()), 32'(exp));
      pulses += int'(out_valid);
      @(posedge CLK); #1;
    end
    chk({tag, " pulses"}, 32'(pulses), 32'(len));
    if (chg) mode_dec = wd;
    last_dec = wd;
  endtask

  initial begin
    int cnt, er, dr;
    bit seen;
    RESET_ = 0; enc_req = 0; dec_req = 0; in_valid = 0; enc_len = 0; dec_len = 0;
    repeat (2) @(negedge CLK);
    chk("reset", 32'(outs()), 32'(0));
    RESET_ = 1;
    @(posedge CLK); #1;
    idle(2);

    run_burst(1, 0, 4, 0, 100, "t1_enc4");
    run_burst(0, 1, 0, 3, 100, "t2_dec3");
    for (int i = 0; i < 4; i++) run_burst(1, 1, 2, 2, 100, $sformatf("t3_tie%0d", i));
    pat = '{1, 0, 0, 1, 1, 0, 1, 1};
    run_burst(1, 0, 5, 0, 100, "t4_gaps");
    run_burst(0, 1, 0, 0, 100, "t5_dec0");
    run_burst(1, 1, 2, 2, 100, "t5_tie");
    idle(1);

    for (int i = 0; i < 20; i++) begin
      er = int'($urandom_range(0, 1));
      dr = (er == 0) ? 1 : int'($urandom_range(0, 1));
      run_burst(bit'(er), bit'(dr), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(40, 100)), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    // Reset while word 2 of a 6-word encode burst is on the input.
    enc_req = 1; enc_len = 6; in_valid = 1;
    @(posedge CLK); #1;
    enc_req = 0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        cnt++;
        if (cnt == 2) seen = 1;
      end
      if (!seen) begin @(posedge CLK); #1; end
    end
    chk("t6_reach_word2", 32'(seen), 32'(1));
    RESET_ = 0;
    #1;
    chk("t6_async", 32'(outs()), 32'(0));
    @(posedge CLK); #1;
    chk("t6_hold", 32'(outs()), 32'(0));
    @(negedge CLK);
    RESET_ = 1;
    mode_dec = 0; last_dec = 1;
    @(posedge CLK); #1;
    idle(1);
    run_burst(1, 0, 3, 0, 100, "t6_restart");
    run_burst(1, 1, 2, 3, 70, "t6_tie");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
